// File: rtl/wb_port_arbiter_if.sv
// Bundle of the writeback-port signals shared by the pipeline, the
// multiply/divide unit and the register file.
//
// Handshake: the MD side offers a result with md_valid; it transfers on a
// clock edge where md_valid && md_ready. Once raised, md_valid and its
// payload stay stable until that transfer. The pipeline side has no ready
// signal. A result offered while pipe_stall is high is not consumed and
// must be held unchanged into the next cycle.
interface wb_port_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
);
   logic                  pipe_valid;
   logic [4:0]            pipe_rd;
   logic [DATA_WIDTH-1:0] pipe_data;
   logic                  pipe_stall;
   logic                  md_valid;
   logic                  md_ready;
   logic [4:0]            md_rd;
   logic [DATA_WIDTH-1:0] md_data;
   logic                  load_regfile;
   logic [4:0]            regfile_dest;
   logic [DATA_WIDTH-1:0] regfile_in;
   logic                  md_retire;
   logic [4:0]            md_retire_rd;
   logic [CNT_W-1:0]      fifo_count;

   // Environment side: pipeline, MD unit, regfile and scoreboard.
   modport master (
      output pipe_valid, pipe_rd, pipe_data, md_valid, md_rd, md_data,
      input  pipe_stall, md_ready, load_regfile, regfile_dest, regfile_in,
             md_retire, md_retire_rd, fifo_count
   );

   // Arbiter side.
   modport slave (
      input  pipe_valid, pipe_rd, pipe_data, md_valid, md_rd, md_data,
      output pipe_stall, md_ready, load_regfile, regfile_dest, regfile_in,
             md_retire, md_retire_rd, fifo_count
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: the pipeline owns the regfile write port by
// default. Multiply/divide results wait in a small FIFO and take the port
// when the pipeline leaves it idle, or force a pipeline stall once they have
// been denied for STARVE_LIMIT cycles. The winning write is registered.
module wb_port_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
   input logic               clk,
   input logic               rst,
   wb_port_arbiter_if.slave  io_bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

   // FIFO storage is not reset: occupancy alone decides what is valid.
   logic [4:0]            r_mem_rd   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic [STV_W-1:0]      r_starve;

   logic                  r_load;
   logic [4:0]            r_dest;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_retire;
   logic [4:0]            r_retire_rd;

   logic                  w_fifo_empty;
   logic                  w_md_ready;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_pipe_needs;
   logic                  w_grant_md;
   logic [4:0]            w_head_rd;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic [CNT_W-1:0]      w_count_nxt;
   logic [STV_W-1:0]      w_starve_nxt;

   // Ready comes from registered occupancy only, so a full FIFO refuses a
   // push even in the cycle it pops; this keeps md_ready off the grant path.
   assign w_fifo_empty = (r_count == '0);
   assign w_md_ready   = !rst && (r_count < DEPTH_C);
   assign w_push       = io_bus.md_valid && w_md_ready;
   assign w_pop        = w_grant_md;
   assign w_pipe_needs = io_bus.pipe_valid && (io_bus.pipe_rd != 5'd0);
   assign w_head_rd    = r_mem_rd[r_rd_ptr];
   assign w_head_data  = r_mem_data[r_rd_ptr];

   // Grant: MD wins when it has data and the pipeline either does not need
   // the port (idle or rd=0) or has starved the FIFO long enough.
   always_comb begin
      w_grant_md = 1'b0;
      if (!w_fifo_empty) begin
         w_grant_md = !w_pipe_needs || (r_starve >= LIMIT_C);
      end
   end

   // Next occupancy and starvation count.
   always_comb begin
      w_count_nxt  = r_count;
      w_starve_nxt = r_starve;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
      if (w_fifo_empty || w_grant_md) begin
         w_starve_nxt = '0;
      end else if (r_starve < LIMIT_C) begin
         w_starve_nxt = r_starve + STV_W'(1);
      end
   end

   // FIFO payload write; the depth is a power of two so pointers wrap
   // naturally.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_rd[r_wr_ptr]   <= io_bus.md_rd;
         r_mem_data[r_wr_ptr] <= io_bus.md_data;
      end
   end

   // FIFO pointers, occupancy and starvation counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_starve <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count  <= w_count_nxt;
         r_starve <= w_starve_nxt;
      end
   end

   // Registered regfile write and retire pulse. An MD entry with rd=0 is
   // retired without writing; dest/data hold when nothing is written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_load      <= 1'b0;
         r_dest      <= 5'd0;
         r_data      <= '0;
         r_retire    <= 1'b0;
         r_retire_rd <= 5'd0;
      end else if (w_grant_md) begin
         r_load      <= (w_head_rd != 5'd0);
         r_dest      <= w_head_rd;
         r_data      <= w_head_data;
         r_retire    <= 1'b1;
         r_retire_rd <= w_head_rd;
      end else begin
         r_load   <= w_pipe_needs;
         r_retire <= 1'b0;
         if (w_pipe_needs) begin
            r_dest <= io_bus.pipe_rd;
            r_data <= io_bus.pipe_data;
         end
      end
   end

   assign io_bus.pipe_stall   = w_grant_md && w_pipe_needs;
   assign io_bus.md_ready     = w_md_ready;
   assign io_bus.load_regfile = r_load;
   assign io_bus.regfile_dest = r_dest;
   assign io_bus.regfile_in   = r_data;
   assign io_bus.md_retire    = r_retire;
   assign io_bus.md_retire_rd = r_retire_rd;
   assign io_bus.fifo_count   = r_count;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios followed by randomized
// traffic, compared against a queue-based reference model.
module tb_wb_port_arbiter;
   localparam int DW    = 32;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int RW    = 5 + DW;

   logic clk = 1'b0;
   logic rst = 1'b1;

   wb_port_arbiter_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   wb_port_arbiter #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;

   logic [RW-1:0] exp_q[$];      // expected regfile writes {rd, data}
   logic [4:0]    exp_ret_q[$];  // expected retire rds
   logic [RW-1:0] md_q[$];       // model of buffered MD results
   int            starve_m = 0;  // cycles the head has been denied
   logic          last_stall = 1'b0;
   logic          last_ready = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model for one cycle, evaluated after inputs settle and before
   // the next rising edge. Writes it predicts appear one edge later.
   task automatic model_step();
      int            sz;
      logic          needs;
      logic          gmd;
      logic          rdy;
      logic [RW-1:0] head;
      sz    = md_q.size();
      needs = bus.pipe_valid && (bus.pipe_rd != 5'd0);
      gmd   = (sz != 0) && (!needs || starve_m >= LIMIT);
      rdy   = (sz < DEPTH);
      check("pipe_stall", bus.pipe_stall, gmd && needs);
      check("md_ready",   bus.md_ready, rdy);
      check("fifo_count", bus.fifo_count, sz);
      if (gmd) begin
         head = md_q.pop_front();
         if (head[RW-1:DW] != 5'd0) exp_q.push_back(head);
         exp_ret_q.push_back(head[RW-1:DW]);
      end else if (needs) begin
         exp_q.push_back({bus.pipe_rd, bus.pipe_data});
      end
      if (bus.md_valid && rdy) md_q.push_back({bus.md_rd, bus.md_data});
      if (sz == 0 || gmd) starve_m = 0;
      else if (starve_m < LIMIT) starve_m++;
      last_stall = gmd && needs;
      last_ready = rdy;
   endtask

   // ---------------- driver ----------------
   task automatic drive_cycle(input logic pv, input logic [4:0] prd, input logic [DW-1:0] pd,
                              input logic mv, input logic [4:0] mrd, input logic [DW-1:0] md);
      @(negedge clk);
      bus.pipe_valid = pv;
      bus.pipe_rd    = prd;
      bus.pipe_data  = pd;
      bus.md_valid   = mv;
      bus.md_rd      = mrd;
      bus.md_data    = md;
      #1;
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
   endtask

   // ---------------- monitor ----------------
   // Every expectation targets the edge right after it was pushed, so after
   // each sample both queues must be empty again.
   initial begin
      logic [RW-1:0] e;
      logic [4:0]    r;
      forever begin
         @(posedge clk);
         #1;
         if (bus.load_regfile) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_write: dest=%0d data=0x%0h expected none at %0t",
                        bus.regfile_dest, bus.regfile_in, $time);
            end else begin
               e = exp_q.pop_front();
               check("wr_dest", bus.regfile_dest, e[RW-1:DW]);
               check("wr_data", bus.regfile_in, e[DW-1:0]);
            end
         end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++; n_fail++;
            $display("FAIL missing_write: got load_regfile=0 expected rd=%0d data=0x%0h at %0t",
                     e[RW-1:DW], e[DW-1:0], $time);
         end
         if (bus.md_retire) begin
            if (exp_ret_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_retire: rd=%0d expected none at %0t", bus.md_retire_rd, $time);
            end else begin
               r = exp_ret_q.pop_front();
               check("retire_rd", bus.md_retire_rd, r);
            end
         end else if (exp_ret_q.size() != 0) begin
            r = exp_ret_q.pop_front();
            n_tests++; n_fail++;
            $display("FAIL missing_retire: got md_retire=0 expected rd=%0d at %0t", r, $time);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic          pv, mv;
      logic [4:0]    prd, mrd;
      logic [DW-1:0] pd, md;
      int            pipe_pct;

      bus.pipe_valid = 1'b0; bus.pipe_rd = 5'd0; bus.pipe_data = '0;
      bus.md_valid   = 1'b0; bus.md_rd   = 5'd0; bus.md_data   = '0;
      #2;
      check("rst_load",     bus.load_regfile, 1'b0);
      check("rst_retire",   bus.md_retire, 1'b0);
      check("rst_count",    bus.fifo_count, 0);
      check("rst_md_ready", bus.md_ready, 1'b0);
      check("rst_dest",     bus.regfile_dest, 5'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Pipeline write with an empty FIFO.
      drive_cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, '0);
      idle(1);

      // Single MD result with the pipeline idle.
      drive_cycle(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'hDEADBEEF);
      idle(2);

      // Starvation: one buffered entry against a continuously busy pipeline.
      drive_cycle(1'b1, 5'd3, 32'h0000_00C3, 1'b1, 5'd9, 32'h0900_0009);
      for (int i = 0; i < 6; i++) drive_cycle(1'b1, 5'd3, 32'h0000_00C3, 1'b0, 5'd0, '0);
      idle(2);

      // FIFO fills while the pipeline saturates the port; push in pop cycle refused.
      for (int i = 0; i < 10; i++) drive_cycle(1'b1, 5'd4, 32'h4444_0000, 1'b1, 5'd12, 32'hC0C0_0012);
      idle(4);

      // Pipe rd=0 while the FIFO holds an entry: MD takes the port, no stall.
      drive_cycle(1'b0, 5'd0, '0, 1'b1, 5'd14, 32'h1414_1414);
      drive_cycle(1'b1, 5'd0, 32'h0000_0BAD, 1'b0, 5'd0, '0);
      idle(1);

      // MD entry with rd=0 is retired but not written.
      drive_cycle(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h5555_5555);
      idle(2);

      // Asynchronous reset with two buffered entries.
      drive_cycle(1'b1, 5'd6, 32'h6666_6666, 1'b1, 5'd20, 32'h2020_2020);
      drive_cycle(1'b1, 5'd6, 32'h6666_6666, 1'b1, 5'd21, 32'h2121_2121);
      @(posedge clk);
      #2;
      check("full_before_rst", bus.fifo_count, 2);
      bus.md_valid = 1'b0;
      bus.pipe_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_count",  bus.fifo_count, 0);
      check("midrst_load",   bus.load_regfile, 1'b0);
      check("midrst_retire", bus.md_retire, 1'b0);
      check("midrst_ready",  bus.md_ready, 1'b0);
      md_q.delete();
      starve_m = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(6);

      // Randomized traffic with varying pipeline load.
      pv = 1'b0; prd = 5'd0; pd = '0; mv = 1'b0; mrd = 5'd0; md = '0;
      last_stall = 1'b0;
      last_ready = 1'b1;
      for (int blk = 0; blk < 6; blk++) begin
         pipe_pct = 30 + 14 * blk;
         for (int c = 0; c < 250; c++) begin
            if (!last_stall) begin
               pv  = ($urandom_range(0, 99) < pipe_pct);
               prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
               pd  = $urandom;
            end
            if (!(mv && !last_ready)) begin
               mv  = ($urandom_range(0, 99) < 35);
               mrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
               md  = $urandom;
            end
            drive_cycle(pv, prd, pd, mv, mrd, md);
         end
      end

      // Drain whatever is still buffered.
      idle(8);
      @(posedge clk);
      #2;
      check("drain_fifo_count", bus.fifo_count, 0);
      check("drain_writes_pending", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback and a long-latency multiply/divide unit.
- Buffers multiply/divide results in a small FIFO and grants them when the pipeline leaves the port idle, or after a bounded starvation time by stalling the pipeline.
- Registers the winning write toward the regfile and reports multiply/divide retirement to the hazard scoreboard.

Parameters:
- DATA_WIDTH, 32, width of write data.
- FIFO_DEPTH, 2, number of buffered multiply/divide results (power of 2, ≥2).
- STARVE_LIMIT, 4, cycles a non-empty FIFO may be denied before the pipeline is stalled.
- CNT_W, $clog2(FIFO_DEPTH+1), width of occupancy count.

Ports:
- clk  in  1  clock
- rst  in  1  reset. Asynchronous, active-high.
- pipe_valid  in  1  pipeline writeback has a result this cycle
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  DATA_WIDTH  pipeline write data
- pipe_stall  out  1  pipeline must hold its WB inputs this cycle (combinational)
- md_valid  in  1  multiply/divide result offered
- md_ready  out  1  FIFO accepts a result this cycle
- md_rd  in  5  multiply/divide destination register
- md_data  in  DATA_WIDTH  multiply/divide result
- load_regfile  out  1  regfile write enable (registered)
- regfile_dest  out  5  regfile write address (registered)
- regfile_in  out  DATA_WIDTH  regfile write data (registered)
- md_retire  out  1  one-cycle pulse: a FIFO entry was written back (registered)
- md_retire_rd  out  5  rd of the retired entry (registered)
- fifo_count  out  CNT_W  current FIFO occupancy

Behaviour:
- Reset (asynchronous):
  - FIFO emptied; pointers, count and starve_cnt set to 0.
  - load_regfile, regfile_dest, regfile_in, md_retire and md_retire_rd all 0.
  - md_ready is 0 while rst is high.
- FIFO:
  - md_ready = !rst && fifo_count < FIFO_DEPTH. It depends on registered state only, so a full FIFO refuses a push even in a cycle that pops.
  - Push when md_valid && md_ready.
  - Pop when the FIFO is granted.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Ordering is FIFO.
- pipe_needs = pipe_valid && pipe_rd != 0.
- Grant (combinational, evaluated each cycle):
  - FIFO empty → grant PIPE.
  - FIFO non-empty and (!pipe_needs or starve_cnt ≥ STARVE_LIMIT) → grant MD.
  - Otherwise → grant PIPE.
- pipe_stall = grant MD && pipe_needs. A pipeline result with rd=0 is never stalled; it is consumed and dropped.
- starve_cnt:
  - Cleared when the FIFO is empty or MD is granted.
  - Otherwise increments by 1 per cycle while the FIFO is non-empty and denied, saturating at STARVE_LIMIT.
- Output register (updates every clock edge, 1-cycle latency from grant):
  - Grant PIPE: load_regfile = pipe_needs; dest and data are taken from pipe_*.
  - Grant MD: load_regfile = (head rd != 0); dest and data are taken from the head entry; md_retire = 1; md_retire_rd = head rd.
  - Entries with rd=0 are popped and retired but not written.
  - No grant: load_regfile = 0 and md_retire = 0. dest and data hold their previous values.
- No WAW/ordering check is performed. The scoreboard guarantees no two in-flight writers share an rd.
- Reset mid-operation: all buffered results are discarded and no write or retire pulse occurs; the scoreboard is reset alongside.

Test Plan:
- Reset, then pipe_valid=1, rd=5, data=0x1234 → next cycle load_regfile=1, regfile_dest=5, regfile_in=0x1234, md_retire=0, pipe_stall=0 throughout.
- Pipeline idle, md_valid=1, rd=7, data=0xDEADBEEF for one cycle → fifo_count=1. Next cycle MD is granted, then load_regfile=1, dest=7, md_retire=1, md_retire_rd=7, fifo_count=0.
- FIFO holds one entry, pipe_valid=1 with rd=3 every cycle → pipe is granted for 4 cycles (starve_cnt 0..3). In cycle 5 pipe_stall=1 and MD is granted; starve_cnt clears and the pipe write follows the next cycle.
- md_valid held high with the pipeline saturating the port → FIFO fills to 2 and md_ready=0. A push attempted in the pop cycle is refused, and fifo_count goes 2→1.
- pipe_valid=1 with rd=0 and the FIFO non-empty → MD is granted with pipe_stall=0; the MD write goes out and the pipe result is dropped.
- MD entry with rd=0 → popped with md_retire=1, md_retire_rd=0, load_regfile=0.
- Assert rst asynchronously while the FIFO holds 2 entries → fifo_count=0, load_regfile=0 and md_retire=0 immediately. After release, no stale write appears.
